// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes and default width for rv_alu.
package alu_pkg;
   localparam int ALU_WIDTH = 64;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: log-stage barrel shifter for SLL/SRL/SRA (left shifts reuse the right shifter via bit reversal).
module alu_shifter #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0]         data_i,
   input  logic [$clog2(WIDTH)-1:0] shamt_i,
   input  logic                     left_i,
   input  logic                     arith_i,
   output logic [WIDTH-1:0]         result_o
);
   localparam int SW = $clog2(WIDTH);
   logic [WIDTH-1:0] rev_in, rev_out;
   logic [WIDTH-1:0] stg [SW+1];
   logic fill;
   assign fill = arith_i & data_i[WIDTH-1];
   for (genvar j = 0; j < WIDTH; j++) begin : g_rev
      assign rev_in[j]  = data_i[WIDTH-1-j];
      assign rev_out[j] = stg[SW][WIDTH-1-j];
   end
   assign stg[0] = left_i ? rev_in : data_i;
   for (genvar i = 0; i < SW; i++) begin : g_stg
      localparam int K = 1 << i;
      assign stg[i+1] = shamt_i[i] ? {{K{fill}}, stg[i][WIDTH-1:K]} : stg[i];
   end
   assign result_o = left_i ? rev_out : stg[SW];
endmodule

// File: rtl/rv_alu.sv
// rv_alu: RISC-V execute-stage ALU with combinational and registered result/zero/overflow.
// Define ALU_EXT_OPS_EN to add XOR, SLL/SRL/SRA, SLT/SLTU and NOR.
module rv_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [3:0]       aluControl,
   output logic [WIDTH-1:0] aluOut,
   output logic             zero,
   output logic             aluResult,
   output logic [WIDTH-1:0] aluOut_q,
   output logic             zero_q,
   output logic             aluResult_q
);
   logic             sub, ovf;
   logic [WIDTH-1:0] b, sum;
`ifdef ALU_EXT_OPS_EN
   logic             carry, slt, sltu;
   logic [WIDTH-1:0] shifted;
   assign sub = aluControl inside {ALU_SUB, ALU_SLT, ALU_SLTU};
   assign {carry, sum} = {1'b0, X} + {1'b0, b} + {{WIDTH{1'b0}}, sub};
   assign slt  = sum[WIDTH-1] ^ ovf;
   assign sltu = ~carry;
   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .data_i   (X),
      .shamt_i  (Y[$clog2(WIDTH)-1:0]),
      .left_i   (aluControl == ALU_SLL),
      .arith_i  (aluControl == ALU_SRA),
      .result_o (shifted)
   );
`else
   assign sub = aluControl == ALU_SUB;
   assign sum = X + b + {{(WIDTH-1){1'b0}}, sub};
`endif
   // One adder serves ADD and SUB: subtraction feeds ~Y with carry-in 1.
   assign b   = sub ? ~Y : Y;
   assign ovf = (X[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
   always_comb begin
      case (aluControl)
         ALU_AND:  aluOut = X & Y;
         ALU_OR:   aluOut = X | Y;
         ALU_ADD:  aluOut = sum;
         ALU_SUB:  aluOut = sum;
`ifdef ALU_EXT_OPS_EN
         ALU_XOR:  aluOut = X ^ Y;
         ALU_SLL:  aluOut = shifted;
         ALU_SRL:  aluOut = shifted;
         ALU_SRA:  aluOut = shifted;
         ALU_SLT:  aluOut = {{(WIDTH-1){1'b0}}, slt};
         ALU_SLTU: aluOut = {{(WIDTH-1){1'b0}}, sltu};
         ALU_NOR:  aluOut = ~(X | Y);
`endif
         default:  aluOut = '0;
      endcase
   end
   assign zero      = aluOut == '0;
   assign aluResult = ovf && (aluControl == ALU_ADD || aluControl == ALU_SUB);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluOut_q    <= '0;
         zero_q      <= 1'b0;
         aluResult_q <= 1'b0;
      end else begin
         aluOut_q    <= aluOut;
         zero_q      <= zero;
         aluResult_q <= aluResult;
      end
   end
endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: scoreboard bench for rv_alu; combinational outputs checked directly, registered ones via queue.
module tb_rv_alu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] X = '0, Y = '0;
   logic [3:0]  aluControl = '0;
   logic [63:0] aluOut, aluOut_q;
   logic        zero, aluResult, zero_q, aluResult_q;
   int          checks = 0, errors = 0;
   logic [65:0] sb[$];

   rv_alu #(.WIDTH(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .X           (X),
      .Y           (Y),
      .aluControl  (aluControl),
      .aluOut      (aluOut),
      .zero        (zero),
      .aluResult   (aluResult),
      .aluOut_q    (aluOut_q),
      .zero_q      (zero_q),
      .aluResult_q (aluResult_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   // Returns {overflow, zero, result}; overflow judged by whether the exact signed sum fits in 64 bits.
   function automatic logic [65:0] model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r;
      logic        v;
      logic signed [65:0] s;
      r = '0;
      v = 1'b0;
      s = '0;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b0010: begin
            s = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
            r = s[63:0];
            v = s[65:63] != {3{s[63]}};
         end
         4'b0110: begin
            s = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
            r = s[63:0];
            v = s[65:63] != {3{s[63]}};
         end
`ifdef ALU_EXT_OPS_EN
         4'b0011: r = x ^ y;
         4'b0100: r = x << y[5:0];
         4'b0101: r = x >> y[5:0];
         4'b1001: r = $signed(x) >>> y[5:0];
         4'b0111: r = {63'b0, $signed(x) < $signed(y)};
         4'b1000: r = {63'b0, x < y};
         4'b1100: r = ~(x | y);
`endif
         default: r = '0;
      endcase
      return {v, r == 64'b0, r};
   endfunction

   task automatic apply(input string tag, input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
      logic [65:0] e;
      @(negedge clk);
      aluControl = op;
      X = x;
      Y = y;
      #1;
      e = model(op, x, y);
      chk({tag, ".out"}, aluOut, e[63:0]);
      chk({tag, ".zero"}, 64'(zero), 64'(e[64]));
      chk({tag, ".ovf"}, 64'(aluResult), 64'(e[65]));
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s.sb got empty want entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".out_q"}, aluOut_q, e[63:0]);
         chk({tag, ".zero_q"}, 64'(zero_q), 64'(e[64]));
         chk({tag, ".ovf_q"}, 64'(aluResult_q), 64'(e[65]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst.out_q", aluOut_q, 64'h0);
      chk("rst.zero_q", 64'(zero_q), 64'h0);
      chk("rst.ovf_q", 64'(aluResult_q), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply("and0", 4'b0000, 64'h0000AAAA, 64'h00000110);
      chk("and0.k", aluOut, 64'h0);
      chk("and0.kz", 64'(zero), 64'h1);
      apply("and1", 4'b0000, 64'hFFFFFFFF, 64'h01010101);
      chk("and1.k", aluOut, 64'h01010101);
      apply("or0", 4'b0001, 64'h0000AAAA, 64'hAAAA0000);
      chk("or0.k", aluOut, 64'hAAAAAAAA);
      apply("or1", 4'b0001, 64'h11001100, 64'h01010101);
      chk("or1.k", aluOut, 64'h11011101);
      apply("add0", 4'b0010, 64'd123, 64'd321);
      chk("add0.k", aluOut, 64'd444);
      apply("addovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      chk("addovf.k", aluOut, 64'h8000_0000_0000_0000);
      chk("addovf.kv", 64'(aluResult), 64'h1);
      apply("sub0", 4'b0110, 64'd128, 64'd64);
      chk("sub0.k", aluOut, 64'd64);
      apply("sub1", 4'b0110, 64'd12345, 64'd2345);
      chk("sub1.k", aluOut, 64'd10000);
      apply("sub2", 4'b0110, 64'd5, 64'd5);
      chk("sub2.kz", 64'(zero), 64'h1);
      apply("subovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1);
      chk("subovf.kv", 64'(aluResult), 64'h1);
      chk("subovf.k", aluOut, 64'h7FFF_FFFF_FFFF_FFFF);
      apply("add1", 4'b0010, 64'd750, 64'd250);
      chk("add1.kq", aluOut_q, 64'd1000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.out_q", aluOut_q, 64'h0);
      chk("midrst.zero_q", 64'(zero_q), 64'h0);
      chk("midrst.ovf_q", 64'(aluResult_q), 64'h0);
      chk("midrst.out", aluOut, 64'd1000);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef ALU_EXT_OPS_EN
      apply("slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      chk("slt.k", aluOut, 64'd1);
      apply("sltu", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      chk("sltu.k", aluOut, 64'd0);
      apply("sra", 4'b1001, 64'h8000_0000_0000_0000, 64'd4);
      chk("sra.k", aluOut, 64'hF800_0000_0000_0000);
      apply("sll", 4'b0100, 64'h0000_0000_0000_0001, 64'd63);
      chk("sll.k", aluOut, 64'h8000_0000_0000_0000);
`else
      apply("xoroff", 4'b0011, 64'h1234, 64'h5678);
      chk("xoroff.k", aluOut, 64'h0);
      chk("xoroff.kz", 64'(zero), 64'h1);
`endif
      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         if (i % 2 == 0) op = (i % 4 == 0) ? 4'b0010 : 4'b0110;
         apply("rnd", op, {$urandom, $urandom}, {$urandom, $urandom});
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
